// File: rtl/jtpopeye_objram_arb_pkg.sv
// jtpopeye_objram_arb_pkg: shared FSM state encoding and default object RAM address width
package jtpopeye_objram_arb_pkg;

    localparam int OBJ_AW = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        GRANT = 2'd2,
        REL   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/jtpopeye_dpram.sv
// jtpopeye_dpram: generic one-write/two-read synchronous RAM with registered, resettable read ports
module jtpopeye_dpram #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re_a,
    input  logic [AW-1:0] raddr_a,
    input  logic          re_b,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] q_a,
    output logic [DW-1:0] q_b
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // write port; array contents are deliberately left untouched by reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // read port A holds its last value when not enabled; old data on a same-address write
    always_ff @(posedge clk) begin
        if (!rst_n) q_a <= '0;
        else if (re_a) q_a <= mem[raddr_a];
    end

    // read port B, independent of port A
    always_ff @(posedge clk) begin
        if (!rst_n) q_b <= '0;
        else if (re_b) q_b <= mem[raddr_b];
    end

endmodule

// File: rtl/jtpopeye_objram_arb.sv
// jtpopeye_objram_arb: object RAM owner answering the video DMA bus handshake (checker: JTPOPEYE_DMACHK_EN)
module jtpopeye_objram_arb
    import jtpopeye_objram_arb_pkg::*;
#(
    parameter int AW   = OBJ_AW,
    parameter int ERRW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cpu_cen,
    input  logic            cpu_mreq_n,
    input  logic            cpu_rd_n,
    input  logic            cpu_wr_n,
    input  logic            obj_cs,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [7:0]      cpu_dout,
    output logic [7:0]      cpu_din,
    input  logic            busrq_n,
    output logic            busak_n,
    input  logic [AW-1:0]   AD_DMA,
    input  logic            dma_cs,
    output logic [7:0]      DD_DMA,
    output logic [ERRW-1:0] dma_err
);

    arb_state_e state_q, state_d;
    logic       busak_d;
    logic       wr_strobe;
    logic       cpu_we;

    // CPU write strobe as seen on the bus, before ownership is considered
    assign wr_strobe = obj_cs & ~cpu_mreq_n & ~cpu_wr_n;
    // the CPU only writes while it still owns the bus
    assign cpu_we    = cpu_cen & wr_strobe & (state_q == IDLE || state_q == DRAIN);

    // state and acknowledge registers; both only move on cpu_cen except on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busak_n <= 1'b1;
        end else begin
            state_q <= state_d;
            busak_n <= busak_d;
        end
    end

    // next state: DRAIN waits for mreq_n high so the CPU machine cycle completes
    always_comb begin
        state_d = state_q;
        if (cpu_cen) begin
            case (state_q)
                IDLE:    state_d = busrq_n ? IDLE : DRAIN;
                DRAIN:   state_d = busrq_n ? IDLE : (cpu_mreq_n ? GRANT : DRAIN);
                GRANT:   state_d = busrq_n ? REL : GRANT;
                default: state_d = IDLE;
            endcase
        end
        busak_d = (state_d != GRANT);
    end

    jtpopeye_dpram #(.DW(8), .AW(AW)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (cpu_we),
        .waddr   (cpu_addr),
        .wdata   (cpu_dout),
        .re_a    (obj_cs & ~cpu_rd_n),
        .raddr_a (cpu_addr),
        .re_b    (dma_cs),
        .raddr_b (AD_DMA),
        .q_a     (cpu_din),
        .q_b     (DD_DMA)
    );

`ifdef JTPOPEYE_DMACHK_EN
    logic [ERRW-1:0] err_q;
    logic            viol;

    assign viol    = (dma_cs & (state_q != GRANT)) | (wr_strobe & (state_q == GRANT));
    assign dma_err = err_q;

    // saturating violation counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= '0;
        else if (viol && err_q != '1) err_q <= err_q + 1'b1;
    end
`else
    assign dma_err = '0;
`endif

endmodule
